hyster_stream: RTL and testbench

- Parametrised hysteresis-threshold stage for the edge-detection pipeline; successor to the fixed 3x3 hysteresis block.
- Accepts one 3-pixel column per handshake, holds a sliding 3x3 window, and emits one binary edge bit per column centre.
- Adds runtime thresholds, an in_valid/in_ready stall handshake, band length COLS with explicit left/right border handling, and a band-done pulse.
- Sits between the non-max-suppression stage and the output packer; the main control issues start once per band.

---
 rtl/hyster_stream.sv | 153 +++++++++++++++
 tb/tb_hyster_stream.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hyster_stream.sv
// Streaming 3x3 hysteresis threshold: one column per handshake in, one edge bit per centre column out.
// Optional HYSTER_BORDER_ZERO_EN forces the first and last centre column of a band to 0.
module hyster_stream #(
  parameter int BIT_LENGTH = 5,
  parameter int COLS       = 16,
  parameter int CNT_W      = $clog2(COLS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIT_LENGTH-1:0] weak_th,
  input  logic [BIT_LENGTH-1:0] strong_th,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIT_LENGTH-1:0] pixel_in0,
  input  logic [BIT_LENGTH-1:0] pixel_in1,
  input  logic [BIT_LENGTH-1:0] pixel_in2,
  output logic                  out_valid,
  output logic                  pixel_out,
  output logic                  band_done,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t                         state_q, state_d;
  logic [2:0][BIT_LENGTH-1:0]     c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic [BIT_LENGTH-1:0]          weak_q, weak_d, strong_q, strong_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           win_vld_q, win_vld_d, win_last_q, win_last_d;
  logic                           out_valid_q, out_valid_d, pixel_out_q, pixel_out_d;
  logic                           band_done_q, band_done_d;
  logic                           accept, nb_strong, edge_bit;
`ifdef HYSTER_BORDER_ZERO_EN
  logic                           win_first_q, win_first_d;
`endif

  assign in_ready = (state_q == S_RUN);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    c0_d       = c0_q;
    c1_d       = c1_q;
    c2_d       = c2_q;
    weak_d     = weak_q;
    strong_d   = strong_q;
    cnt_d      = cnt_q;
    win_vld_d  = 1'b0;
    win_last_d = 1'b0;
`ifdef HYSTER_BORDER_ZERO_EN
    win_first_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          c0_d     = '0;
          c1_d     = '0;
          c2_d     = '0;
          weak_d   = weak_th;
          strong_d = strong_th;
          cnt_d    = '0;
        end
      end
      S_RUN: begin
        if (accept) begin
          c0_d      = c1_q;
          c1_d      = c2_q;
          c2_d      = {pixel_in2, pixel_in1, pixel_in0};
          cnt_d     = cnt_q + CNT_W'(1);
          win_vld_d = (cnt_q != '0);
`ifdef HYSTER_BORDER_ZERO_EN
          win_first_d = (cnt_q == CNT_W'(1));
`endif
          if (cnt_q == CNT_W'(COLS - 1)) state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // Zero column stands in for the right-hand neighbour of the last column.
        c0_d       = c1_q;
        c1_d       = c2_q;
        c2_d       = '0;
        win_vld_d  = 1'b1;
        win_last_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nb_strong = 1'b0;
    for (int r = 0; r < 3; r++) begin
      if (c0_q[r] >= strong_q || c2_q[r] >= strong_q) nb_strong = 1'b1;
    end
    if (c1_q[0] >= strong_q || c1_q[2] >= strong_q) nb_strong = 1'b1;

    if (c1_q[1] >= strong_q)    edge_bit = 1'b1;
    else if (c1_q[1] < weak_q)  edge_bit = 1'b0;
    else                        edge_bit = nb_strong;

    out_valid_d = win_vld_q;
    band_done_d = win_vld_q && win_last_q;
`ifdef HYSTER_BORDER_ZERO_EN
    pixel_out_d = win_vld_q && edge_bit && !win_first_q && !win_last_q;
`else
    pixel_out_d = win_vld_q && edge_bit;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      c0_q        <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      weak_q      <= '0;
      strong_q    <= '0;
      cnt_q       <= '0;
      win_vld_q   <= 1'b0;
      win_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      pixel_out_q <= 1'b0;
      band_done_q <= 1'b0;
`ifdef HYSTER_BORDER_ZERO_EN
      win_first_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      c0_q        <= c0_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      weak_q      <= weak_d;
      strong_q    <= strong_d;
      cnt_q       <= cnt_d;
      win_vld_q   <= win_vld_d;
      win_last_q  <= win_last_d;
      out_valid_q <= out_valid_d;
      pixel_out_q <= pixel_out_d;
      band_done_q <= band_done_d;
`ifdef HYSTER_BORDER_ZERO_EN
      win_first_q <= win_first_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign pixel_out = pixel_out_q;
  assign band_done = band_done_q;

endmodule

// File: tb/tb_hyster_stream.sv
// Bench for hyster_stream: directed test-plan bands plus random bands checked
// against a per-column hysteresis model with an expected-output schedule.
module tb_hyster_stream;
  localparam int BL = 5;
  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset, start, in_valid;
  logic [BL-1:0] weak_th, strong_th, pixel_in0, pixel_in1, pixel_in2;
  logic          in_ready, out_valid, pixel_out, band_done, busy;

  hyster_stream #(.BIT_LENGTH(BL), .COLS(NC)) dut (
    .clk(clk), .reset(reset), .start(start), .weak_th(weak_th), .strong_th(strong_th),
    .in_valid(in_valid), .in_ready(in_ready), .pixel_in0(pixel_in0), .pixel_in1(pixel_in1),
    .pixel_in2(pixel_in2), .out_valid(out_valid), .pixel_out(pixel_out),
    .band_done(band_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int t; bit b; bit d; } exp_t;
  exp_t          q[$];
  logic [BL-1:0] cols [NC][3];
  int            m_weak, m_strong, acc_j, cyc;
  int            nchk = 0, nfail = 0, nvalid = 0, ndone = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pix(int c, int r);
    if (c < 0 || c >= NC) return 0;
    return int'(cols[c][r]);
  endfunction

  // Hysteresis decision for centre column k straight from the rule.
  function automatic bit decide(int k, int w, int s);
    int cen, mx;
`ifdef HYSTER_BORDER_ZERO_EN
    if (k == 0 || k == NC - 1) return 1'b0;
`endif
    cen = pix(k, 1);
    if (cen >= s) return 1'b1;
    if (cen < w) return 1'b0;
    mx = 0;
    for (int dc = -1; dc <= 1; dc++)
      for (int r = 0; r < 3; r++)
        if (!(dc == 0 && r == 1) && pix(k + dc, r) > mx) mx = pix(k + dc, r);
    return mx >= s;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].t == cyc) begin
        chk("out_valid", int'(out_valid), 1);
        chk("pixel_out", int'(pixel_out), int'(q[0].b));
        chk("band_done", int'(band_done), int'(q[0].d));
        void'(q.pop_front());
      end else begin
        chk("quiet out_valid", int'(out_valid), 0);
        chk("quiet pixel_out", int'(pixel_out), 0);
        chk("quiet band_done", int'(band_done), 0);
      end
      if (out_valid) nvalid++;
      if (band_done) ndone++;
      if (in_valid && in_ready) begin
        if (acc_j >= NC) chk("extra accept", acc_j, NC - 1);
        else begin
          if (acc_j >= 1) q.push_back('{cyc + 2, decide(acc_j - 1, m_weak, m_strong), 1'b0});
          if (acc_j == NC - 1) q.push_back('{cyc + 3, decide(NC - 1, m_weak, m_strong), 1'b1});
          acc_j++;
        end
      end
    end
  end

  task automatic clear_cols();
    for (int c = 0; c < NC; c++) for (int r = 0; r < 3; r++) cols[c][r] = '0;
  endtask

  task automatic rand_cols();
    for (int c = 0; c < NC; c++) for (int r = 0; r < 3; r++) cols[c][r] = BL'($urandom_range(0, 31));
  endtask

  task automatic start_band(int w, int s);
    @(posedge clk); #1;
    start = 1'b1; weak_th = BL'(w); strong_th = BL'(s);
    m_weak = w; m_strong = s; acc_j = 0;
    @(posedge clk); #1;
    start = 1'b0;
    // Live thresholds move away from the latched ones for the rest of the band.
    weak_th = BL'(w + 6); strong_th = BL'(s ^ 5);
    chk("busy in band", int'(busy), 1);
  endtask

  // mode 0: in_valid constant, 1: pattern 1,0,0,1,.., 2: random gaps
  task automatic feed(int mode, int ncols);
    int phase = 0;
    for (int k = 0; k < ncols; k++) begin
      bit v;
      int n = 0;
      do begin
        v = (mode == 0) || (mode == 1 && phase % 3 == 0) || (mode == 2 && ($urandom_range(0, 1) == 1)) || n > 6;
        phase++; n++;
        in_valid  = v;
        pixel_in0 = v ? cols[k][0] : BL'($urandom_range(0, 31));
        pixel_in1 = v ? cols[k][1] : BL'($urandom_range(0, 31));
        pixel_in2 = v ? cols[k][2] : BL'($urandom_range(0, 31));
        start     = (mode == 2 && k == 2);
        @(posedge clk); #1;
        start = 1'b0;
      end while (!v);
    end
  endtask

  task automatic finish_band();
    int n = 0;
    int nv0, nd0;
    nv0 = nvalid - (NC - q.size() + 1 > 0 ? 0 : 0);
    // Data ends; in_valid stays high with junk and must be ignored.
    in_valid = 1'b1;
    pixel_in0 = BL'(31); pixel_in1 = BL'(31); pixel_in2 = BL'(31);
    while (q.size() > 0 && n < 40) begin
      @(negedge clk); n++;
      if (n == 3) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    if (q.size() > 0) begin
      chk("drain timeout", q.size(), 0);
      q.delete();
    end
    nd0 = nv0;
    @(posedge clk); #1;
    chk("busy after band", int'(busy), 0);
  endtask

  task automatic run_band(int w, int s, int mode);
    int nv0, nd0;
    nv0 = nvalid; nd0 = ndone;
    start_band(w, s);
    feed(mode, NC);
    finish_band();
    chk("pulses per band", nvalid - nv0, NC);
    chk("band_done per band", ndone - nd0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nd0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; acc_j = 0; cyc = 0;
    weak_th = '0; strong_th = '0; pixel_in0 = '0; pixel_in1 = '0; pixel_in2 = '0;
    #12;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset pixel_out", int'(pixel_out), 0);
    chk("reset band_done", int'(band_done), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset in_ready", int'(in_ready), 0);
    @(negedge clk); reset = 1'b0;

    // single strong centre
    clear_cols(); cols[1][1] = BL'(3);
    chk("pin strong c0", int'(decide(0, 1, 2)), 0);
`ifndef HYSTER_BORDER_ZERO_EN
    chk("pin strong c1", int'(decide(1, 1, 2)), 1);
`endif
    chk("pin strong c2", int'(decide(2, 1, 2)), 0);
    run_band(1, 2, 0);
    run_band(1, 2, 1);

    // weak centre beside strong neighbour
    clear_cols(); cols[1][1] = BL'(1); cols[2][0] = BL'(2);
`ifndef HYSTER_BORDER_ZERO_EN
    chk("pin weak linked", int'(decide(1, 1, 2)), 1);
`endif
    run_band(1, 2, 0);
    cols[2][0] = BL'(1);
    chk("pin weak alone", int'(decide(1, 1, 2)), 0);
    run_band(1, 2, 1);

    // left border
    clear_cols(); cols[0][1] = BL'(1); cols[1][0] = BL'(3);
`ifdef HYSTER_BORDER_ZERO_EN
    chk("pin border", int'(decide(0, 1, 2)), 0);
`else
    chk("pin border", int'(decide(0, 1, 2)), 1);
`endif
    run_band(1, 2, 0);

    // weak above strong
    clear_cols(); cols[1][1] = BL'(4);
`ifndef HYSTER_BORDER_ZERO_EN
    chk("pin weak>strong", int'(decide(1, 6, 3)), 1);
`endif
    run_band(6, 3, 2);

    // reset mid-band, just as the first output is due
    rand_cols();
    nd0 = ndone;
    start_band(1, 2);
    feed(0, 2);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; q.delete(); acc_j = 0;
    #1;
    chk("abort out_valid", int'(out_valid), 0);
    chk("abort pixel_out", int'(pixel_out), 0);
    chk("abort band_done", int'(band_done), 0);
    chk("abort busy", int'(busy), 0);
    chk("abort in_ready", int'(in_ready), 0);
    @(negedge clk); reset = 1'b0;
    chk("abort no band_done", ndone - nd0, 0);
    rand_cols();
    run_band(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)), 0);

    for (int b = 0; b < 40; b++) begin
      rand_cols();
      run_band(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
